// File: rtl/dmem_responder.sv
// Single-port data memory responder with fixed request-to-response latency and RV32I sizing.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_m,
  input  logic        req_we_m,
  input  logic [31:0] req_addr_m,
  input  logic [31:0] req_wdata_m,
  input  logic [2:0]  req_funct3_m,
  output logic        stall_mem,
  output logic        done_m,
  output logic [31:0] rdata_m,
  output logic        err_m
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             capture, go_resp;

  logic             cap_we;
  logic [IDX_W+1:0] cap_addr;
  logic [31:0]      cap_wdata;
  logic [2:0]       cap_funct3;

  logic             acc_we;
  logic [IDX_W+1:0] acc_addr;
  logic [31:0]      acc_wdata;
  logic [2:0]       acc_funct3;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      old_word, new_word, load_val, wlane, resp_rdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [3:0]       wmask;
  logic             load_ok, store_ok, misalign, acc_err, wr_en;
  logic [31:0]      rdata_n;
  logic             err_n;

  logic             unused_addr_hi;
  assign unused_addr_hi = ^req_addr_m[31:IDX_W+2];

  // With LATENCY=1 the access completes on the accept edge, so it must use the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_we     = req_we_m;
      acc_addr   = req_addr_m[IDX_W+1:0];
      acc_wdata  = req_wdata_m;
      acc_funct3 = req_funct3_m;
    end else begin
      acc_we     = cap_we;
      acc_addr   = cap_addr;
      acc_wdata  = cap_wdata;
      acc_funct3 = cap_funct3;
    end
  end

  // Load extraction, store merge and fault decode for the current access.
  always_comb begin
    word_idx = acc_addr[IDX_W+1:2];
    old_word = mem[word_idx];

    case (acc_addr[1:0])
      2'd0:    ld_byte = old_word[7:0];
      2'd1:    ld_byte = old_word[15:8];
      2'd2:    ld_byte = old_word[23:16];
      default: ld_byte = old_word[31:24];
    endcase
    ld_half = acc_addr[1] ? old_word[31:16] : old_word[15:0];

    load_ok  = 1'b1;
    load_val = 32'd0;
    case (acc_funct3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_val = old_word;
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_ok  = 1'b0;
    endcase

    store_ok = 1'b1;
    wmask    = 4'b0000;
    wlane    = acc_wdata;
    case (acc_funct3)
      3'b000: begin
        wmask = 4'b0001 << acc_addr[1:0];
        wlane = {4{acc_wdata[7:0]}};
      end
      3'b001: begin
        wmask = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_wdata[15:0]}};
      end
      3'b010:  wmask    = 4'b1111;
      default: store_ok = 1'b0;
    endcase

    for (int i = 0; i < 4; i++) begin
      new_word[8*i +: 8] = wmask[i] ? wlane[8*i +: 8] : old_word[8*i +: 8];
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) ||
               ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    acc_err    = (acc_we ? !store_ok : !load_ok) || misalign;
    resp_rdata = (acc_we || acc_err) ? 32'd0 : load_val;
  end

  // Next-state, counter and registered-output values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    go_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_m) begin
          capture = 1'b1;
          cnt_n   = CNT_LOAD;
          if (CNT_LOAD == '0) begin
            state_n = RESP;
            go_resp = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_n = RESP;
          go_resp = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    wr_en   = go_resp && acc_we && !acc_err;
    rdata_n = go_resp ? resp_rdata : 32'd0;
    err_n   = go_resp && acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= 32'd0;
      cap_funct3 <= 3'd0;
      rdata_m    <= 32'd0;
      err_m      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_m <= rdata_n;
      err_m   <= err_n;
      if (capture) begin
        cap_we     <= req_we_m;
        cap_addr   <= req_addr_m[IDX_W+1:0];
        cap_wdata  <= req_wdata_m;
        cap_funct3 <= req_funct3_m;
      end
    end
  end

  // Storage has no reset; a reset edge must never commit a store.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[word_idx] <= new_word;
    end
  end

  assign stall_mem = ((state == IDLE) && req_valid_m) || (state == BUSY);
  assign done_m    = (state == RESP);

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit memory words and SHALL be a power of two of at least 4.
REQ-002 Parameter LATENCY, default 2, is the number of cycles from request to response and SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid_m  input  1  memory-stage access request, held stable while stall_mem is high.
REQ-006 req_we_m  input  1  1 = store, 0 = load.
REQ-007 req_addr_m  input  32  byte address.
REQ-008 req_wdata_m  input  32  store data, right-aligned.
REQ-009 req_funct3_m  input  3  access size and signedness (RV32I load/store funct3).
REQ-010 stall_mem  output  1  pipeline hold request while an access is outstanding.
REQ-011 done_m  output  1  one-cycle pulse marking completion of an access.
REQ-012 rdata_m  output  32  load result, extended to 32 bits, valid only while done_m is high.
REQ-013 err_m  output  1  access fault, valid only while done_m is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-015 In IDLE with req_valid_m=1, the block SHALL capture we, addr, wdata and funct3 at the clock edge and load the counter with LATENCY-1.
- Counter value 0 goes to RESP.
- Otherwise it goes to BUSY.
REQ-016 In BUSY the counter SHALL decrement every cycle, and the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-017 A store SHALL commit on the edge that enters RESP, and load data SHALL be sampled on that same edge.
REQ-018 RESP SHALL last exactly one cycle with done_m=1 and SHALL always return to IDLE; a request is never accepted in RESP.
REQ-019 stall_mem SHALL equal (IDLE and req_valid_m) or BUSY, so a request in cycle 0 gives done_m in cycle LATENCY with stall_mem low in that cycle.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-021 Loads SHALL decode funct3 as follows.
- 000 LB: sign-extended byte at addr[1:0].
- 001 LH: sign-extended half at addr[1].
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
REQ-022 Stores SHALL decode funct3 as follows; unaddressed bytes SHALL be unchanged.
- 000 SB: byte lane addr[1:0] written with wdata[7:0].
- 001 SH: half lane addr[1] written with wdata[15:0].
- 010 SW: all four lanes written.
REQ-023 An unsupported funct3 SHALL suppress the write and return rdata_m=0, with err_m=1.
REQ-024 Outside RESP, rdata_m SHALL be 0 and err_m SHALL be 0.
REQ-025 Memory contents SHALL have no reset and SHALL not be initialised by the block.

Reset
REQ-026 Asserting rst at any time SHALL immediately force the following:
- IDLE state and counter 0.
- stall_mem=0 (when req_valid_m=0), done_m=0, rdata_m=0 and err_m=0.
REQ-027 Reset during BUSY SHALL discard the pending access, and no store SHALL commit.
REQ-028 After deassertion the first request SHALL be accepted at the first rising edge with rst low.

Configuration
REQ-029 When macro DMEM_MISALIGN_TRAP_EN is defined, the following accesses SHALL complete with err_m=1, rdata_m=0 and no memory write:
- halfword accesses with addr[0]=1.
- word accesses with addr[1:0]!=0.
REQ-030 When DMEM_MISALIGN_TRAP_EN is undefined, misalignment SHALL never raise err_m.
- Halfword accesses SHALL ignore addr[0].
- Word accesses SHALL ignore addr[1:0].
- err_m SHALL then flag only unsupported funct3.

Verification
REQ-031 LATENCY=2: SW 0xDEADBEEF to 0x10, then LW from 0x10 -> stall_mem high for 2 cycles per access, done_m in cycle 2, rdata_m=0xDEADBEEF.
REQ-032 Write SB 0x80 to 0x13, then LB 0x13 -> rdata_m=0xFFFFFF80; then LBU 0x13 -> rdata_m=0x00000080; then LW 0x10 -> rdata_m=0x80ADBEEF.
REQ-033 LATENCY=1 with back-to-back requests -> done_m on alternate cycles and stall_mem high only in request cycles.
REQ-034 Assert rst in BUSY during SW 0x12345678 to 0x20 -> outputs zero immediately, and a later LW from 0x20 returns the prior value.
REQ-035 With DMEM_MISALIGN_TRAP_EN, SW to 0x22 -> err_m=1 with word unchanged; without the macro, the same store writes word 0x20.
REQ-036 Access to DEPTH_WORDS*4 + 0x10 -> aliases word 0x10.
